// File: rtl/pipe_pkg.sv
// Shared stream constants for the SoftMC instruction/readback paths and a
// small width helper used to size beat counters.
package pipe_pkg;

    localparam int INSN_WIDTH    = 256;
    localparam int RB_BEAT_WIDTH = 64;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ds_state_e;

    // A counter over n values needs at least one bit, even when n <= 2.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_downsizer.sv
// Width downsizer: holds one wide word and emits it as RATIO narrow beats,
// lowest slice first, optionally swallowing all-zero pad words.
module pipe_downsizer
    import pipe_pkg::*;
#(
    parameter int IN_WIDTH  = INSN_WIDTH,
    parameter int OUT_WIDTH = RB_BEAT_WIDTH,
    parameter int DROP_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = clog2_min1(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_cfg
            $error("pipe_downsizer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
        end
    endgenerate

    ds_state_e                     state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [RATIO-1:0][OUT_WIDTH-1:0] word_q, word_d;

    logic last_beat;
    logic out_fire;
    logic in_fire;
    logic in_drop;
    logic load;

    assign last_beat = (state_q == ST_FULL) && (idx_q == LAST_IDX);
    assign out_fire  = (state_q == ST_FULL) && out_ready;
    assign in_fire   = in_valid && in_ready;
    assign in_drop   = (DROP_ZERO != 0) && (in_data == '0);
    assign load      = in_fire && !in_drop;

    // FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (load) state_d = ST_FULL;
            end
            ST_FULL: begin
                // A dropped zero word arriving on the last beat still empties us.
                if (out_fire && last_beat) state_d = load ? ST_FULL : ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // FSM: outputs. in_ready looks at out_ready so the next word can land
    // in the same cycle the last beat leaves.
    always_comb begin
        out_valid = (state_q == ST_FULL);
        busy      = (state_q == ST_FULL);
        out_last  = last_beat;
        in_ready  = (state_q == ST_EMPTY) || (out_fire && last_beat);
        out_data  = word_q[idx_q];
    end

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (load) begin
            word_d = in_data;
            idx_d  = '0;
        end else if (out_fire && !last_beat) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: tb/tb_pipe_downsizer.sv
// Bench for pipe_downsizer: directed scenarios plus a randomized run against
// a queue-of-beats reference model.
module tb_pipe_downsizer;

    localparam int IW = 256;
    localparam int OW = 64;
    localparam int R  = IW / OW;
    localparam int NW = 4000;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;

    logic          nz_in_valid = 1'b0;
    logic [IW-1:0] nz_in_data = '0;
    logic          nz_in_ready;
    logic          nz_out_valid;
    logic [OW-1:0] nz_out_data;
    logic          nz_out_ready = 1'b1;
    logic          nz_out_last;
    logic          nz_busy;

    pipe_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DROP_ZERO(1)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    pipe_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DROP_ZERO(0)) dut_nz (
        .clk(clk), .rstn(rstn),
        .in_valid(nz_in_valid), .in_data(nz_in_data), .in_ready(nz_in_ready),
        .out_valid(nz_out_valid), .out_data(nz_out_data), .out_ready(nz_out_ready),
        .out_last(nz_out_last), .busy(nz_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] sl(input logic [IW-1:0] w, input int k);
        return w[k*OW +: OW];
    endfunction

    function automatic logic [IW-1:0] rnd_word();
        logic [IW-1:0] w;
        for (int k = 0; k < IW/32; k++) w[k*32 +: 32] = $urandom;
        w[0] = 1'b1;
        return w;
    endfunction

    // Reference model: the beats still owed to downstream for the held word.
    logic [OW-1:0] exp_q[$];
    logic          stall_q = 1'b0;
    logic [OW-1:0] stall_data = '0;
    logic          in_fire_s = 1'b0;

    always @(negedge rstn) begin
        exp_q.delete();
        stall_q = 1'b0;
    end

    always @(negedge clk) begin
        if (rstn) begin
            logic exp_ov, exp_rdy;
            exp_ov  = (exp_q.size() != 0);
            exp_rdy = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
            chk("m_ovalid", out_valid, exp_ov);
            chk("m_busy", busy, exp_ov);
            chk("m_inrdy", in_ready, exp_rdy);
            if (exp_ov) begin
                chk("m_odata", out_data, exp_q[0]);
                chk("m_olast", out_last, exp_q.size() == 1);
            end else begin
                chk("m_olast_idle", out_last, 1'b0);
            end
            if (stall_q) begin
                chk("m_stall_valid", out_valid, 1'b1);
                chk("m_stall_data", out_data, stall_data);
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
            in_fire_s  = in_valid && in_ready;
            if (exp_ov && out_ready) void'(exp_q.pop_front());
            if (in_valid && exp_rdy && in_data != '0)
                for (int k = 0; k < R; k++) exp_q.push_back(sl(in_data, k));
        end
    end

    task automatic drive_words(input int sel, input logic [IW-1:0] ws[$]);
        foreach (ws[i]) begin
            int  n;
            logic acc;
            n = 0;
            if (sel != 0) begin nz_in_valid = 1'b1; nz_in_data = ws[i]; end
            else          begin in_valid = 1'b1;    in_data = ws[i];    end
            do begin
                @(negedge clk);
                acc = (sel != 0) ? nz_in_ready : in_ready;
                @(posedge clk); #1;
                n++;
            end while (!acc && n < 50);
            if (!acc) chk("drv_timeout", 1'b0, 1'b1);
        end
        if (sel != 0) nz_in_valid = 1'b0;
        else          in_valid = 1'b0;
    endtask

    task automatic collect(input int sel, input int n, input int bound, output logic [OW-1:0] got[$]);
        int cyc;
        got = {};
        cyc = 0;
        while (got.size() < n && cyc < bound) begin
            @(negedge clk);
            if (sel != 0) begin
                if (nz_out_valid && nz_out_ready) got.push_back(nz_out_data);
            end else begin
                if (out_valid && out_ready) got.push_back(out_data);
            end
            cyc++;
        end
    endtask

    initial begin
        #200_0000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] w1, a, b, c;
        logic [IW-1:0] ws[$];
        logic [OW-1:0] got[$];
        logic [OW-1:0] exp_b[$];
        int sent, cyc;

        w1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

        // reset
        #2 rstn = 1'b0;
        @(negedge clk);
        chk("rst_ovalid", out_valid, 1'b0);
        chk("rst_olast", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_inrdy", in_ready, 1'b1);
        @(posedge clk); #1 rstn = 1'b1;

        // single word, one-cycle latency
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = w1;
        @(negedge clk);
        chk("t1_rdy_empty", in_ready, 1'b1);
        chk("t1_ov_pre", out_valid, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0; in_data = rnd_word();
        for (int k = 0; k < R; k++) begin
            @(negedge clk);
            chk("t1_ov", out_valid, 1'b1);
            chk("t1_data", out_data, sl(w1, k));
            chk("t1_last", out_last, k == R-1);
            chk("t1_rdy", in_ready, k == R-1);
        end
        @(negedge clk);
        chk("t1_idle", out_valid, 1'b0);
        @(posedge clk); #1;

        // back-to-back words, no bubble
        a = rnd_word(); b = rnd_word();
        in_valid = 1'b1; in_data = a;
        @(posedge clk); #1 in_data = b;
        for (int k = 0; k < 2*R; k++) begin
            @(negedge clk);
            chk("t2_ov", out_valid, 1'b1);
            chk("t2_data", out_data, (k < R) ? sl(a, k) : sl(b, k-R));
            chk("t2_last", out_last, (k % R) == R-1);
            if (k < R) chk("t2_rdy", in_ready, k == R-1);
            @(posedge clk); #1;
            if (k == R-1) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("t2_idle", out_valid, 1'b0);
        @(posedge clk); #1;

        // backpressure on the second beat
        in_valid = 1'b1; in_data = w1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t3_b0", out_data, sl(w1, 0));
        @(posedge clk); #1 out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("t3_hold_ov", out_valid, 1'b1);
            chk("t3_hold_data", out_data, sl(w1, 1));
            chk("t3_hold_rdy", in_ready, 1'b0);
            chk("t3_hold_last", out_last, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 1; k < R; k++) begin
            @(negedge clk);
            chk("t3_resume", out_data, sl(w1, k));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t3_idle", out_valid, 1'b0);
        @(posedge clk); #1;

        // zero-word drop vs pass-through
        a = rnd_word(); b = rnd_word();
        ws = {a, '0, b};
        fork
            drive_words(0, ws);
            collect(0, 2*R, 60, got);
        join
        chk("t4_drop_cnt", got.size(), 2*R);
        exp_b = {};
        for (int k = 0; k < R; k++) exp_b.push_back(sl(a, k));
        for (int k = 0; k < R; k++) exp_b.push_back(sl(b, k));
        foreach (got[i]) if (i < 2*R) chk("t4_drop_data", got[i], exp_b[i]);
        @(posedge clk); #1;
        fork
            drive_words(1, ws);
            collect(1, 3*R, 60, got);
        join
        chk("t4_keep_cnt", got.size(), 3*R);
        exp_b = {};
        for (int k = 0; k < R; k++) exp_b.push_back(sl(a, k));
        for (int k = 0; k < R; k++) exp_b.push_back('0);
        for (int k = 0; k < R; k++) exp_b.push_back(sl(b, k));
        foreach (got[i]) if (i < 3*R) chk("t4_keep_data", got[i], exp_b[i]);
        @(posedge clk); #1;

        // async reset mid-word
        a = rnd_word(); c = rnd_word();
        in_valid = 1'b1; in_data = a;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #3 rstn = 1'b0;
        #1;
        chk("t5_rst_ov", out_valid, 1'b0);
        chk("t5_rst_last", out_last, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1 rstn = 1'b1;
        ws = {c};
        fork
            drive_words(0, ws);
            collect(0, R, 30, got);
        join
        chk("t5_cnt", got.size(), R);
        foreach (got[i]) if (i < R) chk("t5_data", got[i], sl(c, i));
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("t5_tail_idle", out_valid, 1'b0);
        end
        @(posedge clk); #1;

        // randomized traffic on both sides
        sent = 0; cyc = 0;
        while ((sent < NW || in_valid || exp_q.size() != 0) && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            if (in_valid && in_fire_s) begin
                sent++;
                in_valid = 1'b0;
            end
            if (!in_valid && sent < NW && $urandom_range(0, 4) != 0) begin
                in_valid = 1'b1;
                in_data  = ($urandom_range(0, 9) == 0) ? '0 : rnd_word();
            end
            out_ready = ($urandom_range(0, 4) != 0);
        end
        chk("t6_timeout", cyc < 60000, 1'b1);
        chk("t6_sent", sent, NW);
        @(negedge clk);
        chk("t6_drained", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
